// File: rtl/scan_reg_chain.sv
// -----------------------------------------------------------------------------
// scan_reg_chain
//
// WIDTH-bit mux-D scan register with complementary outputs, a serial scan
// path and a small auto-shift controller.  The tester either shifts the chain
// one bit per edge with scan_enable, or pulses start once to shift exactly
// WIDTH bits under FSM control.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   D            functional data (WIDTH bits)
//   hold         functional mode: keep Q when high
//   scan_enable  manual shift mode
//   scan_in      serial input, enters at bit 0
//   start        auto-shift request, only acted on in IDLE
//   Q            register value
//   Qbar         registered complement of Q
//   scan_out     Q[WIDTH-1], taken straight from the flop
//   busy         high while the FSM is in SHIFT
//   done         one-cycle pulse while the FSM is in DONE
// -----------------------------------------------------------------------------
module scan_reg_chain #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             hold,
  input  logic             scan_enable,
  input  logic             scan_in,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             scan_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_shift;
  logic             r_busy;
  logic             r_done;

  // Serial path: new bit enters at the LSB, MSB falls out through scan_out.
  assign w_shift = {r_q[WIDTH-2:0], scan_in};

  // Next-Q selection.  The FSM owns the register while it is active; DONE
  // freezes Q so the freshly shifted pattern can be observed for a cycle.
  always_comb begin
    w_q_next = D;
    if (r_state == S_SHIFT) begin
      w_q_next = w_shift;
    end else if (r_state == S_DONE) begin
      w_q_next = r_q;
    end else if (scan_enable) begin
      w_q_next = w_shift;
    end else if (hold) begin
      w_q_next = r_q;
    end
  end

  // Auto-shift controller next-state logic.  cnt counts shifts already
  // performed in SHIFT; the edge that sees CNT_LAST does the final shift.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
          w_cnt_next   = '0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // busy/done are registered alongside the state so they are pure decodes of
  // the state register and never glitch.  Qbar is loaded from the same next
  // value as Q, so it can never lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_qbar  <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_q     <= w_q_next;
      r_qbar  <= ~w_q_next;
      r_busy  <= (w_state_next == S_SHIFT);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  assign Q        = r_q;
  assign Qbar     = r_qbar;
  assign scan_out = r_q[WIDTH-1];
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
